disp_src_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between up to four 16-bit data sources (counters, status words). It selects which source's value and decimal-point position feed the display's `dat`/`PTR` inputs. Selection runs in one of three modes: automatic rotation, manual stepping, or a timed priority override requested by a source. It sits directly upstream of the display driver and paces itself with that driver's `ce1ms` tick.

---
 rtl/disp_src_arbiter.sv | 144 ++++++++++++++
 tb/tb_disp_src_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_src_arbiter.sv
`timescale 1ns/1ps
// disp_src_arbiter: chooses which of up to four sources feeds the 4-digit
// seven-segment display. It supports manual stepping, timed auto-rotation,
// and a timed override that a source can request. Timing is paced by the
// display driver's 1 ms enable.
module disp_src_arbiter #(
  parameter int N_SRC    = 4,
  parameter int DWELL_MS = 1000,
  parameter int HOLD_MS  = 2000,
  parameter int DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce1ms,
  input  logic [4*DATA_W-1:0]   src_dat,
  input  logic [7:0]            src_ptr,
  input  logic [3:0]            req,
  input  logic                  mode_auto,
  input  logic                  btn_next,
  output logic [DATA_W-1:0]     dat,
  output logic [1:0]            PTR,
  output logic [1:0]            sel,
  output logic                  hold
);

  localparam int DW_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
  localparam int HW_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_MS - 1);
  localparam logic [HW_W-1:0] HOLD_LAST  = HW_W'(HOLD_MS - 1);
  localparam logic [3:0]      SRC_MASK   = 4'((1 << N_SRC) - 1);
  localparam logic [1:0]      SEL_LAST   = 2'(N_SRC - 1);

  typedef enum logic [1:0] {
    ST_FIXED = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [1:0]        sel_n;
  logic [1:0]        sel_saved, saved_n;
  logic [DW_W-1:0]   dwell, dwell_n;
  logic [HW_W-1:0]   hcnt, hcnt_n;
  logic [3:0]        req_m;

  // Step to the next active source, wrapping at N_SRC-1.
  function automatic logic [1:0] next_idx(input logic [1:0] s);
    next_idx = (s == SEL_LAST) ? 2'd0 : s + 2'd1;
  endfunction

  // Lowest-numbered requesting source wins.
  function automatic logic [1:0] lowest_req(input logic [3:0] r);
    lowest_req = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) lowest_req = 2'(i);
    end
  endfunction

  assign req_m = req & SRC_MASK;

  // Next-state logic: request beats hold expiry beats button beats dwell expiry.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    saved_n = sel_saved;
    dwell_n = dwell;
    hcnt_n  = hcnt;
    if (req_m != 4'd0) begin
      sel_n   = lowest_req(req_m);
      state_n = ST_HOLD;
      hcnt_n  = '0;
      // Only remember the pre-override source; retargets keep the original.
      if (state != ST_HOLD) saved_n = sel;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (ce1ms) begin
            if (hcnt == HOLD_LAST) begin
              sel_n   = sel_saved;
              state_n = mode_auto ? ST_SCAN : ST_FIXED;
              dwell_n = '0;
              hcnt_n  = '0;
            end else begin
              hcnt_n = hcnt + HW_W'(1);
            end
          end
        end
        ST_FIXED: begin
          if (btn_next) sel_n = next_idx(sel);
          if (mode_auto) begin
            state_n = ST_SCAN;
            dwell_n = '0;
          end
        end
        ST_SCAN: begin
          if (btn_next) begin
            sel_n   = next_idx(sel);
            dwell_n = '0;
          end else if (ce1ms && mode_auto) begin
            if (dwell == DWELL_LAST) begin
              sel_n   = next_idx(sel);
              dwell_n = '0;
            end else begin
              dwell_n = dwell + DW_W'(1);
            end
          end
          if (!mode_auto) state_n = ST_FIXED;
        end
        default: state_n = ST_FIXED;
      endcase
    end
  end

  // Control registers: state, selection, saved selection, counters, hold flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FIXED;
      sel       <= 2'd0;
      sel_saved <= 2'd0;
      dwell     <= '0;
      hcnt      <= '0;
      hold      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      sel_saved <= saved_n;
      dwell     <= dwell_n;
      hcnt      <= hcnt_n;
      hold      <= (state_n == ST_HOLD);
    end
  end

  // Display data stage: one clk behind sel, tracks source changes every clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat <= '0;
      PTR <= 2'b00;
    end else begin
      dat <= src_dat[DATA_W*int'(sel) +: DATA_W];
      PTR <= src_ptr[2*int'(sel) +: 2];
    end
  end

endmodule

// File: tb/tb_disp_src_arbiter.sv
`timescale 1ns/1ps
// Testbench for disp_src_arbiter: directed scenarios followed by a random
// phase, all checked against a tick-counting reference model.
module tb_disp_src_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int HM = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce1ms = 1'b0;
  logic [63:0] src_dat = '0;
  logic [7:0]  src_ptr = '0;
  logic [3:0]  req = '0;
  logic        mode_auto = 1'b0;
  logic        btn_next = 1'b0;
  logic [15:0] dat;
  logic [1:0]  PTR;
  logic [1:0]  sel;
  logic        hold;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 = manual, 1 = rotating, 2 = overridden.
  int          m_mode = 0;
  int          m_sel = 0;
  int          m_saved = 0;
  int          m_dwell_ticks = 0;
  int          m_hold_ticks = 0;
  logic [15:0] m_dat = '0;
  logic [1:0]  m_ptr = '0;
  logic        m_hold = 1'b0;

  always #5 clk = ~clk;

  disp_src_arbiter #(.N_SRC(N), .DWELL_MS(DW), .HOLD_MS(HM)) dut (
    .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .src_dat(src_dat),
    .src_ptr(src_ptr), .req(req), .mode_auto(mode_auto), .btn_next(btn_next),
    .dat(dat), .PTR(PTR), .sel(sel), .hold(hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int winner;
    logic [3:0] r;
    if (!rst_n) begin
      m_mode = 0; m_sel = 0; m_saved = 0;
      m_dwell_ticks = 0; m_hold_ticks = 0;
      m_dat = '0; m_ptr = '0; m_hold = 1'b0;
      return;
    end
    m_dat = src_dat[16*m_sel +: 16];
    m_ptr = src_ptr[2*m_sel +: 2];
    r = req & 4'((1 << N) - 1);
    if (r != 0) begin
      winner = 0;
      while (!r[winner]) winner++;
      if (m_mode != 2) m_saved = m_sel;
      m_sel = winner;
      m_mode = 2;
      m_hold_ticks = 0;
    end else if (m_mode == 2) begin
      if (ce1ms) begin
        m_hold_ticks++;
        if (m_hold_ticks == HM) begin
          m_sel = m_saved;
          m_mode = mode_auto ? 1 : 0;
          m_dwell_ticks = 0;
          m_hold_ticks = 0;
        end
      end
    end else begin
      if (btn_next) begin
        m_sel = (m_sel + 1) % N;
        m_dwell_ticks = 0;
      end
      if (m_mode == 0) begin
        if (mode_auto) begin
          m_mode = 1;
          m_dwell_ticks = 0;
        end
      end else if (!mode_auto) begin
        m_mode = 0;
      end else if (!btn_next && ce1ms) begin
        m_dwell_ticks++;
        if (m_dwell_ticks == DW) begin
          m_sel = (m_sel + 1) % N;
          m_dwell_ticks = 0;
        end
      end
    end
    m_hold = (m_mode == 2);
  endtask

  task automatic step(input logic c, input logic [3:0] r, input logic b);
    ce1ms = c; req = r; btn_next = b;
    @(posedge clk);
    model_edge();
    #1;
    ce1ms = 1'b0; req = 4'd0; btn_next = 1'b0;
    chk("model_sel", 32'(sel), 32'(m_sel));
    chk("model_hold", 32'(hold), 32'(m_hold));
    chk("model_dat", 32'(dat), 32'(m_dat));
    chk("model_ptr", 32'(PTR), 32'(m_ptr));
  endtask

  task automatic tick();
    step(1'b1, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [1:0]  exp_sel [4];
    logic [15:0] exp_dat [4];
    exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{16'h2222, 16'h3333, 16'h4444, 16'h1111};
    src_dat = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_ptr = 8'b11_10_01_00;

    // Reset and manual stepping
    rst_n = 1'b0;
    repeat (3) step(1'b0, 4'd0, 1'b0);
    chk("rst_dat", 32'(dat), 32'h0000);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("release_dat", 32'(dat), 32'h1111);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b1);
      chk("press_sel", 32'(sel), 32'(exp_sel[i]));
      step(1'b0, 4'd0, 1'b0);
      chk("press_dat", 32'(dat), 32'(exp_dat[i]));
    end

    // Auto rotation
    mode_auto = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    repeat (3) tick();
    chk("scan_pre", 32'(sel), 32'd0);
    tick();
    chk("scan_adv", 32'(sel), 32'd1);
    repeat (2) tick();
    step(1'b0, 4'd0, 1'b1);
    chk("scan_btn", 32'(sel), 32'd2);
    repeat (3) tick();
    chk("scan_btn_pre", 32'(sel), 32'd2);
    tick();
    chk("scan_btn_adv", 32'(sel), 32'd3);

    // Override from manual with sel=1
    mode_auto = 1'b0;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("ovr_setup", 32'(sel), 32'd1);
    step(1'b0, 4'b1100, 1'b0);
    chk("ovr_sel", 32'(sel), 32'd2);
    chk("ovr_hold", 32'(hold), 32'd1);
    repeat (5) tick();
    chk("ovr_still", 32'(hold), 32'd1);
    tick();
    chk("ovr_exit_sel", 32'(sel), 32'd1);
    chk("ovr_exit_hold", 32'(hold), 32'd0);
    step(1'b0, 4'd0, 1'b1);
    chk("ovr_fixed", 32'(sel), 32'd2);
    repeat (3) step(1'b0, 4'd0, 1'b1);

    // Retarget during override
    step(1'b0, 4'b1100, 1'b0);
    repeat (2) tick();
    step(1'b1, 4'b1000, 1'b0);
    chk("rt_sel", 32'(sel), 32'd3);
    step(1'b0, 4'd0, 1'b0);
    repeat (5) tick();
    chk("rt_still", 32'(hold), 32'd1);
    tick();
    chk("rt_exit_sel", 32'(sel), 32'd1);
    chk("rt_exit_hold", 32'(hold), 32'd0);

    // Collisions
    step(1'b0, 4'b0001, 1'b1);
    chk("col_sel", 32'(sel), 32'd0);
    chk("col_hold", 32'(hold), 32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("col_btn_ign", 32'(sel), 32'd0);

    // Reset during override
    step(1'b0, 4'b0100, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 4'd0, 1'b0);
    chk("rsth_hold", 32'(hold), 32'd0);
    chk("rsth_sel", 32'(sel), 32'd0);
    chk("rsth_dat", 32'(dat), 32'h0000);
    rst_n = 1'b1;
    repeat (8) tick();
    chk("rsth_norestore", 32'(sel), 32'd0);
    chk("rsth_nohold", 32'(hold), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       c, b;
      logic [3:0] r;
      if ($urandom_range(0, 9) == 0) src_dat = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) src_ptr = 8'($urandom);
      if ($urandom_range(0, 59) == 0) mode_auto = ~mode_auto;
      rst_n = ($urandom_range(0, 599) != 0);
      c = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'd0;
      b = ($urandom_range(0, 11) == 0);
      step(c, r, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
